// File: rtl/seq_pattern_gen.sv
// Serial pattern source: sends a captured PAT_W-bit pattern MSB-first, repeated with idle gaps.
// First bit one cycle after accept; start_ready is low while a transfer (shift or gap) is in flight.
module seq_pattern_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             sop,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             sop_q, sop_d;
  logic             done_q, done_d;
  logic             accept;
  logic             load_msb;

  assign start_ready = (state_q == S_IDLE) && !rst;
  assign accept      = start_valid && start_ready;

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    reps_d      = reps_q;
    gap_d       = gap_q;
    gcnt_d      = gcnt_q;
    idx_d       = idx_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    sop_d       = 1'b0;
    done_d      = 1'b0;
    load_msb    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort is meaningless here, so an accept always wins
        if (accept) begin
          state_d  = S_SHIFT;
          pat_d    = pattern;
          reps_d   = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
          gap_d    = gap;
          load_msb = 1'b1;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (idx_q != '0) begin
          idx_d       = idx_q - 1'b1;
          out_d       = pat_q[idx_q - 1'b1];
          out_valid_d = 1'b1;
        end else if (reps_q > CNT_W'(1)) begin
          reps_d = reps_q - 1'b1;
          if (gap_q != '0) begin
            state_d = S_GAP;
            gcnt_d  = gap_q;
          end else begin
            load_msb = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gcnt_q == GAP_W'(1)) begin
          state_d  = S_SHIFT;
          load_msb = 1'b1;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_msb) begin
      idx_d       = IDX_MSB;
      out_d       = pat_d[PAT_W-1];
      out_valid_d = 1'b1;
      sop_d       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pat_q       <= '0;
      reps_q      <= '0;
      gap_q       <= '0;
      gcnt_q      <= '0;
      idx_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sop_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      reps_q      <= reps_d;
      gap_q       <= gap_d;
      gcnt_q      <= gcnt_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sop_q       <= sop_d;
      done_q      <= done_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sop       = sop_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: directed scenarios then random traffic against a per-cycle trace model.
module tb_seq_pattern_gen;
  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_valid = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [CNT_W-1:0] repeat_cnt = '0;
  logic [GAP_W-1:0] gap = '0;
  logic             abort = 1'b0;
  logic             start_ready, out, out_valid, sop, done;

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .pattern(pattern), .repeat_cnt(repeat_cnt), .gap(gap), .abort(abort),
    .out(out), .out_valid(out_valid), .sop(sop), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  // Expected outputs per cycle, encoded {done, sop, out_valid, out}
  logic [3:0] cur = 4'b0000;
  logic [3:0] fut[$];

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s {ready,done,sop,valid,out} got=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Whole-transfer trace: reps copies of the pattern, gap idle cycles between, then a done pulse
  task automatic build(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] rc, input logic [GAP_W-1:0] g);
    int reps;
    reps = (rc == 0) ? 1 : int'(rc);
    for (int r = 0; r < reps; r++) begin
      if (r > 0)
        for (int k = 0; k < int'(g); k++) fut.push_back(4'b0000);
      for (int i = PAT_W - 1; i >= 0; i--)
        fut.push_back({1'b0, (i == PAT_W - 1), 1'b1, p[i]});
    end
    fut.push_back(4'b1000);
  endtask

  task automatic step(input logic sv, input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] rc,
                      input logic [GAP_W-1:0] g, input logic ab, input logic r);
    logic busy;
    start_valid = sv; pattern = p; repeat_cnt = rc; gap = g; abort = ab; rst = r;
    busy = (fut.size() != 0);
    @(negedge clk);
    check($sformatf("cyc%0d", cyc), {start_ready, done, sop, out_valid, out},
          {(!r && !busy), cur});
    @(posedge clk);
    if (r) begin
      cur = 4'b0000; fut.delete();
    end else if (!busy && sv) begin
      build(p, rc, g); cur = fut.pop_front();
    end else if (busy && ab) begin
      cur = 4'b0000; fut.delete();
    end else if (busy) begin
      cur = fut.pop_front();
    end else begin
      cur = 4'b0000;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    idle(2);

    // single repetition, then busy start requests that must be ignored, then accept in the done cycle
    step(1'b1, 4'b1011, 8'd1, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0000, 8'd5, 4'd3, 1'b0, 1'b0);
    step(1'b1, 4'b0110, 8'd0, 4'd0, 1'b0, 1'b0);
    idle(6);

    // three repetitions with a gap of two
    step(1'b1, 4'b1011, 8'd3, 4'd2, 1'b0, 1'b0);
    idle(19);

    // abort two cycles into a back-to-back pair; abort while idle is harmless
    step(1'b1, 4'b1001, 8'd2, 4'd0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    idle(10);
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // abort during a gap, and abort together with an accept in idle
    step(1'b1, 4'b1110, 8'd3, 4'd5, 1'b0, 1'b0);
    idle(6);
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 4'b0101, 8'd1, 4'd0, 1'b1, 1'b0);
    idle(6);

    // reset in cycle 3 of a gapped transfer
    step(1'b1, 4'b1011, 8'd3, 4'd2, 1'b0, 1'b0);
    idle(2);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    idle(20);

    // maximum repetition count and maximum gap
    step(1'b1, 4'b1101, 8'd255, 4'd0, 1'b0, 1'b0);
    idle(1030);
    step(1'b1, 4'b0011, 8'd3, 4'd15, 1'b0, 1'b0);
    idle(50);

    for (int n = 0; n < 4000; n++) begin
      step(($urandom_range(0, 3) == 0), PAT_W'($urandom), CNT_W'($urandom_range(0, 4)),
           ($urandom_range(0, 2) == 0) ? '0 : GAP_W'($urandom_range(0, 15)),
           ($urandom_range(0, 59) == 0), ($urandom_range(0, 299) == 0));
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
